macc_round_sat: RTL
===================

Name: macc_round_sat

Overview:
- Output stage directly downstream of the 25x18 MACC.
- Consumes the 48-bit product/accumulator `p` and rounds it (round-half-up) with a right shift by SHIFT.
- Saturates the result to OUT_W bits and buffers it in a small FIFO with a valid/ready interface toward the consumer.
- The MACC cannot stall, so overflow of the buffer drops samples and counts the drops; it never back-pressures the MACC.

Parameters:
- IN_W, 48, width of the MACC result `p`.
- OUT_W, 18, width of the rounded/saturated output.
- SHIFT, 12, right-shift amount (1..IN_W-1).
- DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset.
- p_in  in  IN_W  MACC result, unsigned.
- p_valid  in  1  p_in is a valid sample this cycle.
- clr_flags  in  1  synchronous clear of sat_flag, drop_cnt and peak_out.
- out_data  out  OUT_W  FIFO head data.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the head when out_valid=1.
- sat_flag  out  1  sticky; set when any written sample saturated.
- drop_cnt  out  16  count of dropped samples, saturating at 16'hFFFF.
- peak_out  out  OUT_W  see Optional Feature.

Behaviour:
- Reset (rst=0, async):
  - all pipeline valids, FIFO pointers and count go to 0;
  - out_valid=0, out_data=0, sat_flag=0, drop_cnt=0, peak_out=0;
  - release is synchronous to clk.
- Stage 1 (registered):
  - s1 = p_in + 2^(SHIFT-1), computed in IN_W+1 bits so it cannot wrap;
  - s1_v = p_valid.
- Stage 2 (registered):
  - sh = s1 >> SHIFT;
  - if sh > 2^OUT_W-1, then s2 = 2^OUT_W-1 and s2_sat=1; else s2 = sh[OUT_W-1:0];
  - s2_v = s1_v.
- FIFO write:
  - when s2_v=1 and the FIFO is not full (after counting a same-cycle read), write s2;
  - sat_flag is set if s2_sat=1 on a written sample.
- FIFO read:
  - out_valid && out_ready pops the head.
  - Show-ahead: out_data/out_valid are registered and reflect the head one cycle after a write into an empty FIFO.
- Latency: p_valid at cycle N gives out_valid at cycle N+3 when the FIFO is empty and out_ready=1. Throughput is 1 sample/cycle.
- Full: if s2_v=1 and the FIFO is full with no same-cycle pop, the sample is dropped and drop_cnt increments (holds at FFFF). Full with a simultaneous pop and push: both happen and the count is unchanged.
- Empty: out_valid=0 and out_data holds its last value. out_ready is ignored.
- Pointers wrap modulo DEPTH. Count is in range 0..DEPTH.
- clr_flags=1 clears the flags that cycle. If a set or increment coincides with the clear, the clear wins.
- Reset mid-stream: in-flight and buffered samples are discarded. Nothing appears on the output after release until new p_valid samples arrive.

Optional Feature:
- Macro MACC_RS_PEAK_EN.
- Defined: peak_out registers the maximum out value written to the FIFO since reset or clr_flags. The compare uses the written value. clr_flags wins over a same-cycle update.
- Undefined: peak_out is tied to 0 and there is no peak logic.

Decomposition:
- Package macc_pkg holds:
  - MACC_A_W=25, MACC_B_W=18, MACC_P_W=48;
  - DROP_CNT_W=16;
  - a function for the rounded/saturated narrowing, shared with the checker model.
- One sub-module: macc_rs_fifo (parameterised DEPTH/OUT_W, show-ahead, count, full/empty). The round/saturate pipeline stays in the top module.

Test Plan:
- SHIFT=4, OUT_W=18, out_ready=1; p_in=837 (38*22+1) for one cycle → out_data=52 at N+3; sat_flag=0.
- SHIFT=4; p_in=396 (33*12) → out_data=25 (24.75 rounds up). Also p_in=8 → 1 and p_in=7 → 0.
- SHIFT=4; p_in=2^40 → out_data=262143 and sat_flag=1. Then clr_flags pulse → sat_flag=0.
- out_ready=0, DEPTH=4; 6 consecutive p_valid samples 1..6 (times 16) → 4 stored, drop_cnt=2. Then out_ready=1 → pops 1,2,3,4 in order, then out_valid=0.
- FIFO full with out_ready=1 and p_valid every cycle → no drops, count stays 4, drop_cnt unchanged.
- rst low for 1 cycle while 3 samples are buffered and 2 in flight → out_valid=0 immediately and drop_cnt=0. No stale sample after release. With MACC_RS_PEAK_EN, peak_out=0.

Source files
------------

// File: rtl/macc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : macc_pkg
// Purpose  : Shared constants and the round/saturate narrowing helpers used
//            by the MACC output stage.
// Contents : MACC operand/result widths, drop counter width, and the
//            rs_limit / rs_sat / rs_val narrowing functions.
// Revision : 1.0 - initial release
// ============================================================================
package macc_pkg;

  // The 25x18 product is 43 bits. 5 guard bits for accumulation give 48.
  localparam int MACC_A_W     = 25;
  localparam int MACC_B_W     = 18;
  localparam int MACC_GUARD_W = 5;
  localparam int MACC_P_W     = MACC_A_W + MACC_B_W + MACC_GUARD_W;

  localparam int DROP_CNT_W = 16;

  // Widest pre-shift word the helpers handle. One extra bit holds the
  // rounding carry.
  localparam int RS_MAX_W = 64;
  typedef logic [RS_MAX_W:0] rs_word_t;
  localparam rs_word_t RS_ONE = rs_word_t'(1);

  // Largest value representable in out_w unsigned bits.
  function automatic rs_word_t rs_limit(input int out_w);
    return (RS_ONE << out_w) - RS_ONE;
  endfunction

  // s1 already has the rounding constant added. True when the shifted value
  // does not fit in out_w bits.
  function automatic logic rs_sat(input rs_word_t s1, input int shift,
                                  input int out_w);
    return (s1 >> shift) > rs_limit(out_w);
  endfunction

  // Shifted value clamped to the out_w limit. The result is zero above bit
  // out_w-1, so callers may truncate it safely.
  function automatic rs_word_t rs_val(input rs_word_t s1, input int shift,
                                      input int out_w);
    rs_word_t sh;
    sh = s1 >> shift;
    return (sh > rs_limit(out_w)) ? rs_limit(out_w) : sh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/macc_rs_fifo.sv
`default_nettype none
// ============================================================================
// Module   : macc_rs_fifo
// Purpose  : Small show-ahead FIFO with registered head data and valid.
//            A write is refused only when the FIFO is full and no pop happens
//            in the same cycle. The refused write is reported on drop_o.
// Ports    : clk        - rising-edge clock
//            rst        - asynchronous active-low reset
//            wr_en_i    - write request
//            wr_data_i  - write data
//            rd_en_i    - consumer ready; pops the head when valid_o=1
//            rd_data_o  - registered head data (holds its value when empty)
//            valid_o    - registered non-empty flag
//            push_o     - write accepted this cycle
//            drop_o     - write refused this cycle (full, no pop)
// Params   : DEPTH (power of two, >= 2), OUT_W
// Revision : 1.0 - initial release
// ============================================================================
module macc_rs_fifo #(
  parameter int DEPTH = 4,
  parameter int OUT_W = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [OUT_W-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [OUT_W-1:0] rd_data_o,
  output logic             valid_o,
  output logic             push_o,
  output logic             drop_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [OUT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    remain;
  logic [OUT_W-1:0] head_q, head_d;
  logic             valid_q, valid_d;
  logic             push, pop;

  always_comb begin
    pop      = valid_q & rd_en_i;
    push     = wr_en_i & ((count_q != FULL_CNT) | pop);
    remain   = count_q - {{AW{1'b0}}, pop};
    count_d  = remain + {{AW{1'b0}}, push};
    wr_ptr_d = push ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    valid_d  = (count_d != '0);
    // Next head: hold when empty. If no old entry survives the pop, the
    // head is the word being written now, which is not yet in mem_q.
    // Otherwise it is the oldest surviving stored entry.
    if (!valid_d) begin
      head_d = head_q;
    end else if (remain == '0) begin
      head_d = wr_data_i;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
    end
  end

  assign rd_data_o = head_q;
  assign valid_o   = valid_q;
  assign push_o    = push;
  assign drop_o    = wr_en_i & ~push;

endmodule
`default_nettype wire

// File: rtl/macc_round_sat.sv
`default_nettype none
// ============================================================================
// Module   : macc_round_sat
// Purpose  : Output stage after the 25x18 MACC. It rounds the result
//            half-up with a right shift by SHIFT and saturates it to OUT_W
//            bits. It then buffers the result in a show-ahead FIFO. The MACC
//            is never stalled: a sample that meets a full FIFO is dropped
//            and counted.
// Ports    : clk        - rising-edge clock
//            rst        - asynchronous active-low reset
//            p_in       - MACC result (unsigned, IN_W bits)
//            p_valid    - p_in valid this cycle
//            clr_flags  - synchronous clear of sat_flag/drop_cnt/peak_out
//            out_data   - FIFO head data
//            out_valid  - FIFO non-empty
//            out_ready  - consumer accepts the head
//            sat_flag   - sticky: a written sample saturated
//            drop_cnt   - dropped-sample count, saturating
//            peak_out   - largest value written since reset/clear
// Macro    : MACC_RS_PEAK_EN - enables peak tracking. When it is undefined,
//            peak_out is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module macc_round_sat
  import macc_pkg::*;
#(
  parameter int IN_W  = MACC_P_W,
  parameter int OUT_W = 18,
  parameter int SHIFT = 12,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IN_W-1:0]       p_in,
  input  logic                  p_valid,
  input  logic                  clr_flags,
  output logic [OUT_W-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sat_flag,
  output logic [DROP_CNT_W-1:0] drop_cnt,
  output logic [OUT_W-1:0]      peak_out
);

  // Half of the LSB that the shift removes. The add is one bit wider than
  // p_in, so an all-ones input cannot wrap.
  localparam logic [IN_W:0] RND = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);

  // Stage 1: add the rounding constant.
  logic [IN_W:0]  s1_q, s1_d;
  logic           s1_v_q;
  // Stage 2: shift and saturate.
  logic [OUT_W-1:0] s2_q, s2_d;
  logic             s2_sat_q, s2_sat_d;
  logic             s2_v_q;
  // FIFO handshake
  logic             push, drop;
  // Flags
  logic                  sat_flag_q, sat_flag_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    s1_d     = {1'b0, p_in} + RND;
    s2_d     = OUT_W'(rs_val(rs_word_t'(s1_q), SHIFT, OUT_W));
    s2_sat_d = rs_sat(rs_word_t'(s1_q), SHIFT, OUT_W);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q     <= '0;
      s1_v_q   <= 1'b0;
      s2_q     <= '0;
      s2_sat_q <= 1'b0;
      s2_v_q   <= 1'b0;
    end else begin
      s1_q     <= s1_d;
      s1_v_q   <= p_valid;
      s2_q     <= s2_d;
      s2_sat_q <= s2_sat_d;
      s2_v_q   <= s1_v_q;
    end
  end

  macc_rs_fifo #(
    .DEPTH (DEPTH),
    .OUT_W (OUT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (s2_v_q),
    .wr_data_i (s2_q),
    .rd_en_i   (out_ready),
    .rd_data_o (out_data),
    .valid_o   (out_valid),
    .push_o    (push),
    .drop_o    (drop)
  );

  // A clear has priority over a set or increment in the same cycle.
  always_comb begin
    sat_flag_d = sat_flag_q | (push & s2_sat_q);
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
    end
    if (clr_flags) begin
      sat_flag_d = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_flag_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      sat_flag_q <= sat_flag_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign sat_flag = sat_flag_q;
  assign drop_cnt = drop_cnt_q;

`ifdef MACC_RS_PEAK_EN
  logic [OUT_W-1:0] peak_q, peak_d;

  // Track the largest value actually written. Dropped samples do not count.
  always_comb begin
    peak_d = peak_q;
    if (push && (s2_q > peak_q)) begin
      peak_d = s2_q;
    end
    if (clr_flags) begin
      peak_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign peak_out = peak_q;
`else
  assign peak_out = '0;
`endif

endmodule
`default_nettype wire
